// File: rtl/prime_check_seq_if.sv
// Request/result bundle for the sequential prime tester.
// The requester drives start/number; the tester answers with busy, done,
// is_prime and factor.
interface prime_check_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] number;
   logic             busy;
   logic             done;
   logic             is_prime;
   logic [WIDTH-1:0] factor;

   modport master (
      output start, number,
      input  busy, done, is_prime, factor
   );

   modport slave (
      input  start, number,
      output busy, done, is_prime, factor
   );
endinterface

// File: rtl/prime_check_seq.sv
// Sequential primality tester using odd trial division. Each candidate
// divisor is run through a bit-serial restoring remainder, one operand bit
// per cycle. Reports the verdict and the smallest prime factor of
// composite operands.
module prime_check_seq #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   prime_check_seq_if.slave bus
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SCREEN,
      TEST,
      DIV,
      EVAL,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] n;
   logic [WIDTH-1:0] d;
   logic [WIDTH:0]   rem;
   logic [IW-1:0]    idx;

   logic             busy_q;
   logic             done_q;
   logic             prime_q;
   logic [WIDTH-1:0] factor_q;

   logic [2*WIDTH-1:0] d_sq;
   logic               d_sq_gt_n;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_nx;

   // Trial-limit test and one restoring-remainder step.
   always_comb begin
      // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
      d_sq      = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
      d_sq_gt_n = d_sq > {{WIDTH{1'b0}}, n};
      rem_sh    = {rem[WIDTH-1:0], n[idx]};
      rem_nx    = (rem_sh >= {1'b0, d}) ? (rem_sh - {1'b0, d}) : rem_sh;
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
         state    <= IDLE;
         n        <= '0;
         d        <= '0;
         rem      <= '0;
         idx      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         prime_q  <= 1'b0;
         factor_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  n        <= bus.number;
                  prime_q  <= 1'b0;
                  factor_q <= '0;
                  busy_q   <= 1'b1;
                  state    <= SCREEN;
               end
            end

            SCREEN: begin
               if (n < WIDTH'(2)) begin
                  prime_q <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= DONE;
               end else if (n == WIDTH'(2) || n == WIDTH'(3)) begin
                  prime_q <= 1'b1;
                  done_q  <= 1'b1;
                  state   <= DONE;
               end else if (!n[0]) begin
                  factor_q <= WIDTH'(2);
                  done_q   <= 1'b1;
                  state    <= DONE;
               end else begin
                  d     <= WIDTH'(3);
                  state <= TEST;
               end
            end

            TEST: begin
               if (d_sq_gt_n) begin
                  prime_q <= 1'b1;
                  done_q  <= 1'b1;
                  state   <= DONE;
               end else begin
                  rem   <= '0;
                  idx   <= IW'(WIDTH - 1);
                  state <= DIV;
               end
            end

            DIV: begin
               rem <= rem_nx;
               idx <= idx - 1'b1;
               if (idx == '0) begin
                  state <= EVAL;
               end
            end

            EVAL: begin
               if (rem == '0) begin
                  factor_q <= d;
                  done_q   <= 1'b1;
                  state    <= DONE;
               end else begin
                  d     <= d + WIDTH'(2);
                  state <= TEST;
               end
            end

            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.is_prime = prime_q;
   assign bus.factor   = factor_q;

endmodule

// File: tb/tb_prime_check_seq.sv
// Self-checking bench for prime_check_seq: three instances (WIDTH 8, 16, 4)
// compared against a plain trial-division reference model.
module tb_prime_check_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   prime_check_seq_if #(.WIDTH(8))  b8 ();
   prime_check_seq_if #(.WIDTH(16)) b16 ();
   prime_check_seq_if #(.WIDTH(4))  b4 ();

   prime_check_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
   prime_check_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
   prime_check_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int wsel(input int sel);
      return (sel == 0) ? 8 : (sel == 1) ? 16 : 4;
   endfunction

   task automatic drive(input int sel, input logic st, input int num);
      case (sel)
         0: begin b8.start  = st; b8.number  = num[7:0];  end
         1: begin b16.start = st; b16.number = num[15:0]; end
         default: begin b4.start = st; b4.number = num[3:0]; end
      endcase
   endtask

   task automatic sample(input int sel, output logic bsy, output logic dn,
                         output logic pr, output logic [31:0] fac);
      case (sel)
         0: begin bsy = b8.busy;  dn = b8.done;  pr = b8.is_prime;  fac = {24'd0, b8.factor};  end
         1: begin bsy = b16.busy; dn = b16.done; pr = b16.is_prime; fac = {16'd0, b16.factor}; end
         default: begin bsy = b4.busy; dn = b4.done; pr = b4.is_prime; fac = {28'd0, b4.factor}; end
      endcase
   endtask

   // Reference: plain trial division plus the documented latency formulas.
   task automatic model(input int w, input int num, output logic pr,
                        output int fac, output int lat);
      longint d;
      int k;
      pr = 1'b0; fac = 0; lat = 2;
      if (num < 2) return;
      if (num == 2 || num == 3) begin pr = 1'b1; return; end
      if (num % 2 == 0) begin fac = 2; return; end
      k = 0;
      d = 3;
      while (d * d <= longint'(num)) begin
         k++;
         if (num % int'(d) == 0) begin
            fac = int'(d);
            lat = 2 + k * (w + 2);
            return;
         end
         d += 2;
      end
      pr  = 1'b1;
      lat = 3 + k * (w + 2);
   endtask

   // One transaction: optional start pulse injected in cycle inj_cycle and/or
   // in the DONE cycle, with a different operand; number is scrambled after
   // acceptance.
   task automatic run(input string tag, input int sel, input int num,
                      input int inj_cycle, input int inj_num, input bit inj_done,
                      output int lat);
      logic bsy, dn, pr, epr;
      logic [31:0] fac;
      int efac, elat;
      bit inj;
      model(wsel(sel), num, epr, efac, elat);
      @(negedge clk);
      drive(sel, 1'b1, num);
      lat = -1;
      for (int c = 1; c <= 4000; c++) begin
         @(negedge clk);
         sample(sel, bsy, dn, pr, fac);
         if (c == 1) check({tag, "_busy_rise"}, {31'd0, bsy}, 32'd1);
         inj = (c == inj_cycle) || (dn && inj_done);
         drive(sel, inj, inj ? inj_num : int'($urandom));
         if (dn) begin
            lat = c;
            break;
         end
      end
      check({tag, "_latency"}, lat, elat);
      check({tag, "_is_prime"}, {31'd0, pr}, {31'd0, epr});
      check({tag, "_factor"}, fac, efac);
      @(negedge clk);
      sample(sel, bsy, dn, pr, fac);
      drive(sel, 1'b0, 0);
      check({tag, "_done_fall"}, {31'd0, dn}, 32'd0);
      check({tag, "_busy_fall"}, {31'd0, bsy}, 32'd0);
      check({tag, "_hold_prime"}, {31'd0, pr}, {31'd0, epr});
      check({tag, "_hold_factor"}, fac, efac);
   endtask

   initial begin
      int lat;
      int t[3];
      int nd;
      logic bsy, dn, pr;
      logic [31:0] fac;

      drive(0, 1'b0, 0);
      drive(1, 1'b0, 0);
      drive(2, 1'b0, 0);

      // Reset state
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sample(s, bsy, dn, pr, fac);
         check("reset_busy", {31'd0, bsy}, 32'd0);
         check("reset_done", {31'd0, dn}, 32'd0);
         check("reset_prime", {31'd0, pr}, 32'd0);
         check("reset_factor", fac, 32'd0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Screening cases, WIDTH=8
      run("scr0", 0, 0, -1, 0, 0, lat);   check("scr0_L", lat, 2);
      run("scr1", 0, 1, -1, 0, 0, lat);   check("scr1_L", lat, 2);
      run("scr2", 0, 2, -1, 0, 0, lat);   check("scr2_L", lat, 2);
      run("scr3", 0, 3, -1, 0, 0, lat);   check("scr3_L", lat, 2);
      run("scr4", 0, 4, -1, 0, 0, lat);   check("scr4_L", lat, 2);
      run("scr20", 0, 20, -1, 0, 0, lat); check("scr20_L", lat, 2);

      // Odd cases with spec latencies as independent constants
      run("odd7", 0, 7, -1, 0, 0, lat);     check("odd7_L", lat, 3);
      run("odd9", 0, 9, -1, 0, 0, lat);     check("odd9_L", lat, 12);
      run("odd25", 0, 25, -1, 0, 0, lat);   check("odd25_L", lat, 22);
      run("odd221", 0, 221, -1, 0, 0, lat); check("odd221_L", lat, 62);
      run("odd251", 0, 251, -1, 0, 0, lat); check("odd251_L", lat, 73);
      run("odd255", 0, 255, -1, 0, 0, lat); check("odd255_L", lat, 12);

      // Full sweep, WIDTH=8
      for (int v = 0; v < 256; v++) run("sweep8", 0, v, -1, 0, 0, lat);

      // Ignored starts during DIV and during DONE
      run("inj251", 0, 251, 5, 9, 1'b1, lat);  check("inj251_L", lat, 73);
      run("inj221", 0, 221, 20, 4, 1'b1, lat); check("inj221_L", lat, 62);

      // Start held high with number=7: done every 4 cycles
      @(negedge clk);
      drive(0, 1'b1, 7);
      nd = 0;
      for (int c = 1; c <= 40 && nd < 3; c++) begin
         @(negedge clk);
         sample(0, bsy, dn, pr, fac);
         if (dn) begin
            t[nd] = c;
            nd++;
            check("b2b_prime", {31'd0, pr}, 32'd1);
         end
      end
      drive(0, 1'b0, 0);
      check("b2b_count", nd, 3);
      check("b2b_first", t[0], 3);
      check("b2b_gap1", t[1] - t[0], 4);
      check("b2b_gap2", t[2] - t[1], 4);
      repeat (6) @(negedge clk);

      // Reset mid-operation
      @(negedge clk);
      drive(0, 1'b1, 251);
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         drive(0, 1'b0, 0);
      end
      rst_n = 1'b0;
      #1;
      sample(0, bsy, dn, pr, fac);
      check("mid_rst_busy", {31'd0, bsy}, 32'd0);
      check("mid_rst_done", {31'd0, dn}, 32'd0);
      check("mid_rst_factor", fac, 32'd0);
      check("mid_rst_prime", {31'd0, pr}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         sample(0, bsy, dn, pr, fac);
         if (dn || bsy) nd++;
      end
      check("mid_rst_no_done", nd, 0);
      run("post_rst9", 0, 9, -1, 0, 0, lat); check("post_rst9_L", lat, 12);

      // Width scaling
      run("w16_65521", 1, 65521, -1, 0, 0, lat); check("w16_65521_L", lat, 2289);
      run("w16_65535", 1, 65535, -1, 0, 0, lat); check("w16_65535_L", lat, 20);
      for (int i = 0; i < 8; i++) run("w16_rand", 1, int'($urandom_range(0, 65535)), -1, 0, 0, lat);
      run("w4_15", 2, 15, -1, 0, 0, lat); check("w4_15_L", lat, 8);
      for (int v = 0; v < 16; v++) run("sweep4", 2, v, -1, 0, 0, lat);

      // Random WIDTH=8 operands with random ignored-start injection
      for (int i = 0; i < 20; i++)
         run("rand8", 0, int'($urandom_range(0, 255)), int'($urandom_range(2, 40)),
             int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), lat);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
